load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage between execute and retire.
- Accepts one load/store per handshake from execute and drives the data-memory port with a word-aligned address, byte write strobes and replicated store data.
- Holds the request until memory responds, then presents the raw read word and the address byte offset to retire, which performs byte/half extraction and sign extension.
- Flags misaligned accesses and memory timeouts instead of issuing them.

Parameters:
- TIMEOUT_CYCLES, 255: cycles REQUEST may wait for mem_ready_i before a bus error is raised; legal range 1..65535.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_i  input  1  execute presents an operation this cycle.
- instruction_operation_i  input  iType_e  operation; LB, LBU, LH, LHU, LW, SB, SH and SW are memory ops, all others are ignored.
- address_i  input  32  effective byte address (rs1 + imm).
- store_data_i  input  32  rs2 value; only low byte/half used for SB/SH.
- ready_o  output  1  LSU can accept an operation; high only in IDLE.
- mem_operation_enable_o  output  1  memory request active.
- mem_address_o  output  32  {addr[31:2], 2'b00}.
- mem_write_enable_o  output  4  byte strobes; 0000 for loads.
- mem_write_data_o  output  32  lane-replicated store data.
- mem_ready_i  input  1  memory accepted the write or has read data valid on mem_data_i this cycle.
- mem_data_i  input  32  read word from memory.
- done_o  output  1  one-cycle pulse: operation completed.
- load_data_o  output  32  raw word captured for the last completed load.
- offset_o  output  2  addr[1:0] of the last accepted operation.
- misaligned_o  output  1  one-cycle pulse: access rejected for misalignment.
- bus_error_o  output  1  one-cycle pulse: timeout reached.

Behaviour:
- Reset (asynchronous):
  - state = IDLE; ready_o = 1.
  - All other outputs = 0; counter = 0.
- States: IDLE, REQUEST.
- IDLE:
  - A handshake occurs when valid_i & ready_o & memory op.
  - Non-memory ops and valid_i = 0 are ignored; no output changes.
- Alignment check at handshake:
  - LH/LHU/SH misaligned if addr[0] = 1.
  - LW/SW misaligned if addr[1:0] != 00.
  - Byte ops are never misaligned.
  - Misaligned: misaligned_o = 1 next cycle only; no memory request; stay IDLE; done_o stays 0.
- Aligned handshake:
  - Register operation, address, strobes, write data and offset_o; go to REQUEST.
- Strobes and write data:
  - SB: 0001 << addr[1:0]; data = {4{store_data_i[7:0]}}.
  - SH: 0011 if addr[1] = 0, else 1100; data = {2{store_data_i[15:0]}}.
  - SW: 1111; data = store_data_i.
  - Loads: 0000; write data = 0.
- REQUEST:
  - mem_operation_enable_o = 1; address, strobes and data stay stable every cycle until exit.
  - On an edge with mem_ready_i = 1: go to IDLE and pulse done_o for one cycle. For loads, load_data_o <= mem_data_i; for stores, load_data_o is unchanged.
  - Otherwise counter increments.
  - When counter = TIMEOUT_CYCLES-1 with mem_ready_i = 0: bus_error_o pulses, go to IDLE, no done_o.
  - mem_ready_i on the final cycle takes priority over the timeout.
  - Counter clears on entry to REQUEST.
- Latency:
  - Minimum 2 cycles from handshake edge to done_o: handshake at edge 0, REQUEST with mem_ready_i at edge 1, done_o high in the cycle after edge 1.
  - ready_o is high in the done_o cycle, so back-to-back operations have a throughput of one per 2 cycles with zero-wait memory.
- Hold behaviour: offset_o and load_data_o hold until the next aligned handshake or the next load completion respectively.
- mem_ready_i while in IDLE is ignored.
- Reset mid-REQUEST: request dropped immediately (asynchronous); no done_o; state = IDLE.

Test Plan:
- LW at 0x0000_1008, mem_ready_i held 1, mem_data_i = 0xDEADBEEF -> mem_address_o = 0x1008, strobes 0000, done_o pulse 2 cycles after handshake, load_data_o = 0xDEADBEEF, offset_o = 00.
- SB at 0x0000_2003, store_data_i = 0x123456AB -> mem_address_o = 0x2000, strobes 1000, mem_write_data_o = 0xABABABAB; SH at 0x2002, data 0xCAFE -> strobes 1100, data 0xCAFECAFE.
- LH at 0x0000_3001 and SW at 0x3002 -> misaligned_o pulse for each, mem_operation_enable_o never asserts, done_o stays 0, ready_o stays 1.
- LW with mem_ready_i delayed 5 cycles -> mem_operation_enable_o, address and strobes stable 6 cycles; done_o one cycle after the mem_ready_i edge; ready_o = 0 throughout REQUEST.
- TIMEOUT_CYCLES = 4, SW with mem_ready_i = 0 forever -> bus_error_o pulse after 4 REQUEST cycles, enable drops, no done_o; a subsequent LB is accepted normally.
- Assert reset on the second REQUEST cycle of a load -> enable and all outputs 0 immediately, ready_o = 1 after release, no done_o.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-access stage: issues word-aligned data-memory requests from
// execute and returns the raw read word and byte offset to retire.
package lsu_pkg;

    typedef enum logic [4:0] {
        NOP, ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT,
        LUI, AUIPC, JAL, JALR, BEQ, BNE,
        LB, LBU, LH, LHU, LW, SB, SH, SW
    } iType_e;

endpackage

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  iType_e      instruction_operation_i,
    input  logic [31:0] address_i,
    input  logic [31:0] store_data_i,
    output logic        ready_o,
    output logic        mem_operation_enable_o,
    output logic [31:0] mem_address_o,
    output logic [3:0]  mem_write_enable_o,
    output logic [31:0] mem_write_data_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_data_i,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic [1:0]  offset_o,
    output logic        misaligned_o,
    output logic        bus_error_o
);

    typedef enum logic {IDLE, REQUEST} state_e;

    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state;
    state_e      state_next;
    logic [15:0] count;
    logic        load_q;

    logic        is_mem;
    logic        is_load;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        handshake;
    logic        accept;
    logic        finish;
    logic        timeout;
    logic [3:0]  strobe;
    logic [31:0] wdata;

    assign ready_o                = (state == IDLE);
    assign mem_operation_enable_o = (state == REQUEST);

    // Classify the incoming operation and check its alignment.
    always_comb begin
        is_mem  = 1'b0;
        is_load = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        case (instruction_operation_i)
            LB, LBU: begin is_mem = 1'b1; is_load = 1'b1; end
            LH, LHU: begin is_mem = 1'b1; is_load = 1'b1; is_half = 1'b1; end
            LW:      begin is_mem = 1'b1; is_load = 1'b1; is_word = 1'b1; end
            SB:      begin is_mem = 1'b1; end
            SH:      begin is_mem = 1'b1; is_half = 1'b1; end
            SW:      begin is_mem = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
        misaligned = (is_half & address_i[0])
                   | (is_word & (address_i[1:0] != 2'b00));
        handshake  = valid_i & ready_o & is_mem;
        accept     = handshake & ~misaligned;
    end

    // Byte strobes and lane-replicated store data.
    always_comb begin
        strobe = 4'b0000;
        wdata  = 32'h0;
        if (!is_load) begin
            unique case (1'b1)
                is_word: begin
                    strobe = 4'b1111;
                    wdata  = store_data_i;
                end
                is_half: begin
                    strobe = address_i[1] ? 4'b1100 : 4'b0011;
                    wdata  = {2{store_data_i[15:0]}};
                end
                default: begin
                    strobe = 4'b0001 << address_i[1:0];
                    wdata  = {4{store_data_i[7:0]}};
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state; memory response wins over the timeout.
    always_comb begin
        state_next = state;
        finish     = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = REQUEST;
            end
            REQUEST: begin
                if (mem_ready_i) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (count == LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request registers, wait counter, load capture and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count              <= 16'h0;
            load_q             <= 1'b0;
            mem_address_o      <= 32'h0;
            mem_write_enable_o <= 4'b0000;
            mem_write_data_o   <= 32'h0;
            offset_o           <= 2'b00;
            load_data_o        <= 32'h0;
            done_o             <= 1'b0;
            misaligned_o       <= 1'b0;
            bus_error_o        <= 1'b0;
        end else begin
            done_o       <= finish;
            bus_error_o  <= timeout;
            misaligned_o <= handshake & misaligned;
            if (accept) begin
                count              <= 16'h0;
                load_q             <= is_load;
                mem_address_o      <= {address_i[31:2], 2'b00};
                mem_write_enable_o <= strobe;
                mem_write_data_o   <= wdata;
                offset_o           <= address_i[1:0];
            end else if (state == REQUEST && !mem_ready_i) begin
                count <= count + 16'd1;
            end
            if (finish && load_q) load_data_o <= mem_data_i;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a default instance plus a
// short-timeout instance used for the bus-error scenario.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    iType_e      op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        mem_ready;
    logic [31:0] mem_data;

    logic        ready, en, done, mis, berr;
    logic [31:0] maddr, wdata, ldata;
    logic [3:0]  strb;
    logic [1:0]  off;

    logic        valid_to, mem_ready_to;
    logic        ready_to, en_to, done_to, mis_to, berr_to;
    logic [31:0] maddr_to, wdata_to, ldata_to;
    logic [3:0]  strb_to;
    logic [1:0]  off_to;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset), .valid_i(valid),
        .instruction_operation_i(op), .address_i(addr),
        .store_data_i(sdata), .ready_o(ready),
        .mem_operation_enable_o(en), .mem_address_o(maddr),
        .mem_write_enable_o(strb), .mem_write_data_o(wdata),
        .mem_ready_i(mem_ready), .mem_data_i(mem_data),
        .done_o(done), .load_data_o(ldata), .offset_o(off),
        .misaligned_o(mis), .bus_error_o(berr)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset(reset), .valid_i(valid_to),
        .instruction_operation_i(op), .address_i(addr),
        .store_data_i(sdata), .ready_o(ready_to),
        .mem_operation_enable_o(en_to), .mem_address_o(maddr_to),
        .mem_write_enable_o(strb_to), .mem_write_data_o(wdata_to),
        .mem_ready_i(mem_ready_to), .mem_data_i(mem_data),
        .done_o(done_to), .load_data_o(ldata_to), .offset_o(off_to),
        .misaligned_o(mis_to), .bus_error_o(berr_to)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid = 1'b0; valid_to = 1'b0;
        op = NOP; addr = 32'h0; sdata = 32'h0;
        mem_ready = 1'b0; mem_ready_to = 1'b0; mem_data = 32'h0;
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
        checks++;
        if ({en, done, mis, berr} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {en, done, mis, berr}); end
        checks++;
        if ({maddr, wdata, ldata, strb, off} !== 70'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {maddr, wdata, ldata, strb, off}); end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_lw();
        valid = 1'b1; op = LW; addr = 32'h0000_1008;
        mem_ready = 1'b1; mem_data = 32'hDEADBEEF;
        step();
        valid = 1'b0;
        checks++;
        if ({en, ready} !== 2'b10) begin errors++; $display("FAIL lw_req en/ready got %b exp 10", {en, ready}); end
        checks++;
        if (maddr !== 32'h1008 || strb !== 4'b0000) begin errors++; $display("FAIL lw_addr got %h/%b exp 00001008/0000", maddr, strb); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL lw_early_done got %b exp 0", done); end
        step();
        checks++;
        if ({done, ready, en} !== 3'b110) begin errors++; $display("FAIL lw_done got %b exp 110", {done, ready, en}); end
        checks++;
        if (ldata !== 32'hDEADBEEF || off !== 2'b00) begin errors++; $display("FAIL lw_data got %h/%b exp deadbeef/00", ldata, off); end
        step();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL lw_pulse got %b exp 0", done); end
        mem_ready = 1'b0;
    endtask

    task automatic test_stores();
        valid = 1'b1; op = SB; addr = 32'h0000_2003; sdata = 32'h123456AB;
        step();
        valid = 1'b0;
        checks++;
        if (maddr !== 32'h2000 || strb !== 4'b1000) begin errors++; $display("FAIL sb_addr got %h/%b exp 00002000/1000", maddr, strb); end
        checks++;
        if (wdata !== 32'hABABABAB || off !== 2'b11) begin errors++; $display("FAIL sb_data got %h/%b exp abababab/11", wdata, off); end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || ldata !== 32'hDEADBEEF) begin errors++; $display("FAIL sb_done got %b/%h exp 1/deadbeef", done, ldata); end
        valid = 1'b1; op = SH; addr = 32'h0000_2002; sdata = 32'h0000CAFE;
        step();
        valid = 1'b0;
        checks++;
        if (strb !== 4'b1100 || wdata !== 32'hCAFECAFE) begin errors++; $display("FAIL sh_data got %b/%h exp 1100/cafecafe", strb, wdata); end
        checks++;
        if (maddr !== 32'h2000 || off !== 2'b10) begin errors++; $display("FAIL sh_addr got %h/%b exp 00002000/10", maddr, off); end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL sh_done got %b exp 1", done); end
        step();
    endtask

    task automatic test_misaligned();
        valid = 1'b1; op = LH; addr = 32'h0000_3001;
        step();
        checks++;
        if ({mis, en, done, ready} !== 4'b1001) begin errors++; $display("FAIL lh_mis got %b exp 1001", {mis, en, done, ready}); end
        checks++;
        if (off !== 2'b10) begin errors++; $display("FAIL lh_mis_off got %b exp 10", off); end
        op = SW; addr = 32'h0000_3002;
        step();
        valid = 1'b0;
        checks++;
        if ({mis, en, done, ready} !== 4'b1001) begin errors++; $display("FAIL sw_mis got %b exp 1001", {mis, en, done, ready}); end
        step();
        checks++;
        if ({mis, en, done, ready} !== 4'b0001) begin errors++; $display("FAIL mis_pulse got %b exp 0001", {mis, en, done, ready}); end
    endtask

    task automatic test_ignore();
        valid = 1'b1; op = ADD; addr = 32'h0000_5004; mem_ready = 1'b1;
        step();
        valid = 1'b0;
        step();
        checks++;
        if ({en, done, mis, ready} !== 4'b0001) begin errors++; $display("FAIL ignore_flags got %b exp 0001", {en, done, mis, ready}); end
        checks++;
        if (off !== 2'b10 || maddr !== 32'h2000) begin errors++; $display("FAIL ignore_hold got %b/%h exp 10/00002000", off, maddr); end
        mem_ready = 1'b0;
    endtask

    task automatic test_wait();
        valid = 1'b1; op = LW; addr = 32'h0000_1004; mem_data = 32'h13579BDF;
        step();
        valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({en, ready, done} !== 3'b100 || maddr !== 32'h1004 || strb !== 4'b0000) begin
                errors++;
                $display("FAIL wait_stable[%0d] got %b/%h/%b exp 100/00001004/0000", i, {en, ready, done}, maddr, strb);
            end
            if (i == 5) mem_ready = 1'b1;
            else step();
        end
        step();
        mem_ready = 1'b0;
        checks++;
        if ({done, ready, en} !== 3'b110 || ldata !== 32'h13579BDF) begin errors++; $display("FAIL wait_done got %b/%h exp 110/13579bdf", {done, ready, en}, ldata); end
        step();
    endtask

    task automatic test_back_to_back();
        valid = 1'b1; op = LW; addr = 32'h0000_0010;
        mem_ready = 1'b1; mem_data = 32'hA5A5_0001;
        step();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b exp 0", ready); end
        step();
        op = LBU; addr = 32'h0000_0013; mem_data = 32'h0BAD_F00D;
        checks++;
        if ({done, ready} !== 2'b11 || ldata !== 32'hA5A50001) begin errors++; $display("FAIL b2b_first got %b/%h exp 11/a5a50001", {done, ready}, ldata); end
        step();
        valid = 1'b0;
        checks++;
        if ({en, off} !== 3'b111) begin errors++; $display("FAIL b2b_second_req got %b exp 111", {en, off}); end
        step();
        mem_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || ldata !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_second got %b/%h exp 1/0badf00d", done, ldata); end
        step();
    endtask

    task automatic test_timeout();
        valid_to = 1'b1; op = SW; addr = 32'h0000_0040; sdata = 32'h1111_2222;
        mem_ready_to = 1'b0;
        step();
        valid_to = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({en_to, berr_to, done_to} !== 3'b100) begin errors++; $display("FAIL to_wait[%0d] got %b exp 100", i, {en_to, berr_to, done_to}); end
            step();
        end
        checks++;
        if ({berr_to, en_to, done_to, ready_to} !== 4'b1001) begin errors++; $display("FAIL to_err got %b exp 1001", {berr_to, en_to, done_to, ready_to}); end
        step();
        checks++;
        if ({berr_to, done_to} !== 2'b00) begin errors++; $display("FAIL to_pulse got %b exp 00", {berr_to, done_to}); end
        valid_to = 1'b1; op = LB; addr = 32'h0000_0041;
        mem_ready_to = 1'b1; mem_data = 32'h0000_7700;
        step();
        valid_to = 1'b0;
        checks++;
        if (en_to !== 1'b1 || strb_to !== 4'b0000 || off_to !== 2'b01) begin errors++; $display("FAIL to_lb_req got %b/%b/%b exp 1/0000/01", en_to, strb_to, off_to); end
        step();
        mem_ready_to = 1'b0;
        checks++;
        if (done_to !== 1'b1 || ldata_to !== 32'h00007700) begin errors++; $display("FAIL to_lb_done got %b/%h exp 1/00007700", done_to, ldata_to); end
        step();
    endtask

    task automatic test_reset_mid();
        valid = 1'b1; op = LW; addr = 32'h0000_0054; mem_ready = 1'b0;
        step();
        valid = 1'b0;
        step();
        checks++;
        if (en !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b exp 1", en); end
        reset = 1'b1;
        #1;
        checks++;
        if ({en, done, ready} !== 3'b001) begin errors++; $display("FAIL rst_mid_flags got %b exp 001", {en, done, ready}); end
        checks++;
        if ({maddr, ldata, off} !== 66'h0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", {maddr, ldata, off}); end
        step();
        reset = 1'b0;
        mem_ready = 1'b1;
        step();
        checks++;
        if ({ready, done, en} !== 3'b100) begin errors++; $display("FAIL rst_mid_after got %b exp 100", {ready, done, en}); end
        mem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_stores();
        test_misaligned();
        test_ignore();
        test_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
